// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: recovers pixel coordinates, a valid strobe and
// frame markers from an HSYNC/VSYNC/RGB stream, and tracks lock against the mode.
module vga_sync_decoder #(
    parameter int unsigned H_START     = 144,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_START     = 35,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET_N,
    input  logic       VGA_HSYNC,
    input  logic       VGA_VSYNC,
    input  logic [7:0] VGA_RED,
    input  logic [7:0] VGA_GREEN,
    input  logic [7:0] VGA_BLUE,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       PIX_VALID,
    output logic [7:0] PIX_RED,
    output logic [7:0] PIX_GREEN,
    output logic [7:0] PIX_BLUE,
    output logic       FRAME_START,
    output logic       LOCKED,
    output logic [7:0] ERR_COUNT
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [10:0] HS   = 11'(H_START);
    localparam logic [10:0] HE   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] HT   = 11'(H_TOTAL);
    localparam logic [10:0] HMAX = 11'(2 * H_TOTAL);
    localparam logic [9:0]  VS   = 10'(V_START);
    localparam logic [9:0]  VE   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  VT   = 10'(V_TOTAL);
    localparam logic [7:0]  LF   = 8'(LOCK_FRAMES);

    logic        hs_s1_q, vs_s1_q, hs_prev_q, vs_prev_q;
    logic [7:0]  r_s1_q, g_s1_q, b_s1_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        vs_fell_q, vs_fell_d;
    logic        skip_q, skip_d;
    logic [1:0]  state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  err_q, err_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        valid_q, valid_d, fs_q, fs_d, locked_q, locked_d;
    logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;

    logic hs_edge, vs_edge, restart, tracking;
    logic bad_line, bad_frame, timeout, violation, good_frame;
    logic lock_next, active;

    // hcnt_d/vcnt_d are the coordinates of the sample currently in S1; the _q
    // copies belong to the previous sample, which is what line/frame checks need.
    assign hs_edge   = hs_prev_q & ~hs_s1_q;
    assign vs_edge   = vs_prev_q & ~vs_s1_q;
    assign restart   = hs_edge & (vs_edge | vs_fell_q);
    assign hcnt_d    = hs_edge ? '0 : ((hcnt_q == HMAX) ? hcnt_q : hcnt_q + 11'd1);
    assign vcnt_d    = !hs_edge ? vcnt_q :
                       restart ? '0 : ((vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1);
    assign vs_fell_d = hs_edge ? 1'b0 : (vs_fell_q | vs_edge);

    assign tracking   = (state_q != ST_SEARCH);
    assign bad_line   = tracking & hs_edge & ~skip_q & (hcnt_q + 11'd1 != HT);
    assign bad_frame  = tracking & restart & (vcnt_q + 10'd1 != VT);
    assign timeout    = tracking & ~hs_edge & (hcnt_q == HMAX - 11'd1);
    assign violation  = bad_line | bad_frame | timeout;
    assign good_frame = tracking & restart & ~violation;
    assign skip_d     = violation ? 1'b1 : (hs_edge ? 1'b0 : skip_q);
    assign err_d      = (violation && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_edge) begin
                    state_d = ST_CHECK;
                    good_d  = '0;
                end
            end
            ST_CHECK: begin
                if (violation) begin
                    state_d = ST_SEARCH;
                end else if (good_frame) begin
                    good_d = good_q + 8'd1;
                    if (good_d == LF) state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (violation) state_d = ST_SEARCH;
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Internal lock is reached at a frame restart, but LOCKED is only raised
    // together with the first FRAME_START so the reported frame is complete.
    assign lock_next = (state_d == ST_LOCKED);
    assign active    = (hcnt_d >= HS) && (hcnt_d < HE) && (vcnt_d >= VS) && (vcnt_d < VE);
    assign valid_d   = active & lock_next;
    assign fs_d      = valid_d & (hcnt_d == HS) & (vcnt_d == VS);
    assign locked_d  = lock_next & (locked_q | fs_d);
    assign pix_x_d   = active ? 10'(hcnt_d - HS) : '0;
    assign pix_y_d   = active ? (vcnt_d - VS) : '0;
    assign red_d     = valid_d ? r_s1_q : '0;
    assign green_d   = valid_d ? g_s1_q : '0;
    assign blue_d    = valid_d ? b_s1_q : '0;

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_s1_q   <= 1'b1;
            vs_s1_q   <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            r_s1_q    <= '0;
            g_s1_q    <= '0;
            b_s1_q    <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vs_fell_q <= 1'b0;
            skip_q    <= 1'b1;
            state_q   <= ST_SEARCH;
            good_q    <= '0;
            err_q     <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            locked_q  <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            hs_s1_q   <= VGA_HSYNC;
            vs_s1_q   <= VGA_VSYNC;
            hs_prev_q <= hs_s1_q;
            vs_prev_q <= vs_s1_q;
            r_s1_q    <= VGA_RED;
            g_s1_q    <= VGA_GREEN;
            b_s1_q    <= VGA_BLUE;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            vs_fell_q <= vs_fell_d;
            skip_q    <= skip_d;
            state_q   <= state_d;
            good_q    <= good_d;
            err_q     <= err_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            locked_q  <= locked_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign PIX_VALID   = valid_q;
    assign PIX_RED     = red_q;
    assign PIX_GREEN   = green_q;
    assign PIX_BLUE    = blue_q;
    assign FRAME_START = fs_q;
    assign LOCKED      = locked_q;
    assign ERR_COUNT   = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced video mode (10x6 clocks,
// 5x3 active) so lock, violation and saturation scenarios fit in a short run.
module tb_vga_sync_decoder;

    localparam int HS = 3;
    localparam int HA = 5;
    localparam int HT = 10;
    localparam int VS = 2;
    localparam int VA = 3;
    localparam int VT = 6;

    logic       CLK_25MHZ = 1'b0;
    logic       RESET_N;
    logic       VGA_HSYNC, VGA_VSYNC;
    logic [7:0] VGA_RED, VGA_GREEN, VGA_BLUE;
    logic [9:0] PIX_X, PIX_Y;
    logic       PIX_VALID, FRAME_START, LOCKED;
    logic [7:0] PIX_RED, PIX_GREEN, PIX_BLUE, ERR_COUNT;

    always #5 CLK_25MHZ = ~CLK_25MHZ;

    vga_sync_decoder #(
        .H_START(HS), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_START(VS), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .CLK_25MHZ(CLK_25MHZ), .RESET_N(RESET_N),
        .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC),
        .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .PIX_VALID(PIX_VALID),
        .PIX_RED(PIX_RED), .PIX_GREEN(PIX_GREEN), .PIX_BLUE(PIX_BLUE),
        .FRAME_START(FRAME_START), .LOCKED(LOCKED), .ERR_COUNT(ERR_COUNT)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int gen_line = 0, gen_col = 0;
    logic [7:0] d0_r = '0, d0_g = '0, d0_b = '0, d1_r = '0, d1_g = '0, d1_b = '0;
    int d0_ln = 0, d0_col = 0, d1_ln = 0, d1_col = 0;
    int nvalid, nfs, nrise, nrise_fs, colour_bad, coord_bad, fx, fy, lx, ly;
    logic locked_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        nvalid = 0; nfs = 0; nrise = 0; nrise_fs = 0;
        colour_bad = 0; coord_bad = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    endtask

    // Drive one clock of stimulus, then observe outputs on the next falling edge;
    // those outputs belong to the sample driven one call earlier (2-clock latency).
    task automatic step(input logic hs, input logic vs);
        d1_r = d0_r; d1_g = d0_g; d1_b = d0_b; d1_ln = d0_ln; d1_col = d0_col;
        d0_r = cyc[7:0]; d0_g = cyc[15:8] ^ 8'h5A; d0_b = cyc[7:0] ^ 8'hC3;
        d0_ln = gen_line; d0_col = gen_col;
        VGA_HSYNC = hs; VGA_VSYNC = vs;
        VGA_RED = d0_r; VGA_GREEN = d0_g; VGA_BLUE = d0_b;
        cyc++;
        @(negedge CLK_25MHZ);
        if (PIX_VALID) begin
            if (nvalid == 0) begin fx = int'(PIX_X); fy = int'(PIX_Y); end
            lx = int'(PIX_X); ly = int'(PIX_Y);
            nvalid++;
            if ({PIX_RED, PIX_GREEN, PIX_BLUE} !== {d1_r, d1_g, d1_b}) colour_bad++;
            if (PIX_X !== 10'(d1_col - HS) || PIX_Y !== 10'(d1_ln - VS)) coord_bad++;
        end else if ({PIX_RED, PIX_GREEN, PIX_BLUE} !== 24'd0) begin
            colour_bad++;
        end
        if (FRAME_START) nfs++;
        if (LOCKED && !locked_prev) begin
            nrise++;
            if (FRAME_START && PIX_X == 10'd0 && PIX_Y == 10'd0) nrise_fs++;
        end
        locked_prev = LOCKED;
    endtask

    task automatic send_line(input int ln, input int from, input int to);
        for (int c = from; c < to; c++) begin
            gen_line = ln; gen_col = c;
            step(c < 2 ? 1'b0 : 1'b1, ln < 2 ? 1'b0 : 1'b1);
        end
    endtask

    task automatic send_frame(input int nlines, input int short_ln);
        for (int l = 0; l < nlines; l++) send_line(l, 0, (l == short_ln) ? HT - 1 : HT);
    endtask

    task automatic run_frames(input int n);
        clear_stats();
        for (int f = 0; f < n; f++) send_frame(VT, -1);
    endtask

    task automatic relock_check(input string tag);
        run_frames(2);
        chk({tag, "_pre_locked"}, 32'(LOCKED), 32'd0);
        chk({tag, "_pre_valid"}, 32'(nvalid), 32'd0);
        run_frames(1);
        chk({tag, "_rise_at_fs"}, 32'(nrise_fs), 32'd1);
        chk({tag, "_rises"}, 32'(nrise), 32'd1);
        chk({tag, "_nvalid"}, 32'(nvalid), 32'(HA * VA));
        chk({tag, "_first_xy"}, 32'(fx * 1000 + fy), 32'd0);
        chk({tag, "_last_xy"}, 32'(lx * 1000 + ly), 32'((HA - 1) * 1000 + VA - 1));
        chk({tag, "_colour"}, 32'(colour_bad), 32'd0);
        chk({tag, "_coord"}, 32'(coord_bad), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; VGA_HSYNC = 1'b1; VGA_VSYNC = 1'b1;
        VGA_RED = '0; VGA_GREEN = '0; VGA_BLUE = '0;
        clear_stats();
        repeat (3) @(negedge CLK_25MHZ);
        chk("rst_locked", 32'(LOCKED), 32'd0);
        chk("rst_valid", 32'(PIX_VALID), 32'd0);
        chk("rst_err", 32'(ERR_COUNT), 32'd0);
        chk("rst_xy", 32'({PIX_X, PIX_Y}), 32'd0);
        RESET_N = 1'b1;
        repeat (5) step(1'b1, 1'b1);
        chk("idle_locked", 32'(LOCKED), 32'd0);

        // Nominal stream: lock at FRAME_START of the 3rd frame, then a full frame.
        relock_check("nominal");
        run_frames(1);
        chk("nominal_f4_nvalid", 32'(nvalid), 32'(HA * VA));
        chk("nominal_f4_fs", 32'(nfs), 32'd1);
        chk("nominal_f4_colour", 32'(colour_bad), 32'd0);
        chk("nominal_err", 32'(ERR_COUNT), 32'd0);

        // Short line (HT-1) on active line 3; caught at line 4's HSYNC edge.
        for (int l = 0; l < 3; l++) send_line(l, 0, HT);
        send_line(3, 0, HT - 1);
        clear_stats();
        send_line(4, 0, 1);
        chk("short_still_locked", 32'(LOCKED), 32'd1);
        send_line(4, 1, 2);
        chk("short_locked_drop", 32'(LOCKED), 32'd0);
        chk("short_valid_drop", 32'(PIX_VALID), 32'd0);
        chk("short_err", 32'(ERR_COUNT), 32'd1);
        send_line(4, 2, HT);
        send_line(5, 0, HT);
        chk("short_no_valid_after", 32'(nvalid), 32'd0);
        relock_check("short_relock");

        // Missing HSYNC: hold high well beyond the 2*HT timeout.
        clear_stats();
        repeat (4 * HT) step(1'b1, 1'b1);
        chk("timeout_locked", 32'(LOCKED), 32'd0);
        chk("timeout_err", 32'(ERR_COUNT), 32'd2);
        relock_check("timeout_relock");
        chk("timeout_err_after", 32'(ERR_COUNT), 32'd2);

        // Frame one line short; caught at the next VSYNC restart.
        send_frame(VT - 1, -1);
        send_line(0, 0, 1);
        chk("vshort_still_locked", 32'(LOCKED), 32'd1);
        send_line(0, 1, 2);
        chk("vshort_locked_drop", 32'(LOCKED), 32'd0);
        chk("vshort_err", 32'(ERR_COUNT), 32'd3);
        send_line(0, 2, HT);
        for (int l = 1; l < VT; l++) send_line(l, 0, HT);
        relock_check("vshort_relock");

        // Asynchronous reset in the middle of an active line.
        for (int l = 0; l < 3; l++) send_line(l, 0, HT);
        send_line(3, 0, 6);
        chk("pre_reset_valid", 32'(PIX_VALID), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        chk("areset_locked", 32'(LOCKED), 32'd0);
        chk("areset_valid", 32'(PIX_VALID), 32'd0);
        chk("areset_xy", 32'({PIX_X, PIX_Y}), 32'd0);
        chk("areset_rgb", 32'({PIX_RED, PIX_GREEN, PIX_BLUE}), 32'd0);
        chk("areset_err", 32'(ERR_COUNT), 32'd0);
        repeat (2) @(negedge CLK_25MHZ);
        RESET_N = 1'b1;
        send_line(3, 6, HT);
        send_line(4, 0, HT);
        send_line(5, 0, HT);
        relock_check("areset_relock");

        // 300 violations: each frame enters CHECK then hits a short line.
        for (int k = 1; k <= 300; k++) begin
            send_frame(VT, 1);
            if (k == 254) chk("sat_254", 32'(ERR_COUNT), 32'd254);
            if (k == 255) chk("sat_255", 32'(ERR_COUNT), 32'd255);
        end
        chk("sat_300", 32'(ERR_COUNT), 32'd255);
        chk("sat_locked", 32'(LOCKED), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart to the VGA timing generator: samples a VGA stream (HSYNC, VSYNC, 8-bit RGB) from the same 25 MHz pixel clock domain and recovers pixel coordinates, a data-valid strobe and frame markers. It checks line and frame lengths against the expected mode and reports lock status. The block sits on the loopback/capture path for self-checking the video pipeline and driving a frame-capture sink.

## Interface
- `H_START`, 144: clocks from the HSYNC leading edge to the first active pixel.
- `H_ACTIVE`, 640: active pixels per line.
- `H_TOTAL`, 800: expected clocks per line.
- `V_START`, 35: lines from the VSYNC leading edge to the first active line.
- `V_ACTIVE`, 480: active lines per frame.
- `V_TOTAL`, 525: expected lines per frame.
- `LOCK_FRAMES`, 2: consecutive good frames required before lock.
- `CLK_25MHZ`  in  1  pixel clock; all logic is on its rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `VGA_HSYNC`  in  1  horizontal sync, active-low.
- `VGA_VSYNC`  in  1  vertical sync, active-low.
- `VGA_RED`, `VGA_GREEN`, `VGA_BLUE`  in  8 each  pixel colour.
- `PIX_X`  out  10  column of the current active pixel; 0 outside active.
- `PIX_Y`  out  10  row of the current active pixel; 0 outside active.
- `PIX_VALID`  out  1  high for active pixels, and only while LOCKED.
- `PIX_RED`, `PIX_GREEN`, `PIX_BLUE`  out  8 each  colour, aligned with `PIX_VALID`; 0 when not valid.
- `FRAME_START`  out  1  one-cycle pulse aligned with pixel (0,0), only while LOCKED.
- `LOCKED`  out  1  timing lock status.
- `ERR_COUNT`  out  8  saturating count of timing violations.

## Operation
- **Input stage.** All inputs are registered once (stage S1). Leading edges are detected on S1: `hs_edge` is S1 HSYNC low while the previous S1 value was high; `vs_edge` is derived the same way from VSYNC.
- **Horizontal counter.** `hcnt` is 11 bits. It loads 0 on `hs_edge` and otherwise increments, saturating at 2*H_TOTAL.
- **Vertical counter.** `vcnt` is 10 bits. On `hs_edge` it loads 0 if `vs_edge` is also true, or if VSYNC fell since the last `hs_edge`; otherwise it increments, saturating at 1023.
- **Active region.** A pixel is active when H_START ≤ hcnt < H_START+H_ACTIVE and V_START ≤ vcnt < V_START+V_ACTIVE.
  - `PIX_X` = hcnt−H_START.
  - `PIX_Y` = vcnt−V_START.
- **Line check.** At each `hs_edge`, the previous line is good only if hcnt+1 equals H_TOTAL. The first edge after SEARCH entry is not checked.
- **Frame check.** At each VSYNC-qualified line restart, the previous frame is good only if vcnt+1 equals V_TOTAL and all lines in that frame were good.
- **Timeout.** hcnt reaching 2*H_TOTAL is a violation (lost HSYNC).
- **FSM states:** SEARCH, CHECK, LOCKED.
  - SEARCH → CHECK on the first `vs_edge`; the good-frame counter clears.
  - CHECK: a good frame increments the counter. When the counter reaches LOCK_FRAMES, go to LOCKED.
  - CHECK or LOCKED → SEARCH on any violation, whether a bad line, a bad frame or a timeout. Each violation increments `ERR_COUNT`, which saturates at 255.
  - LOCKED remains until a violation occurs.
- **Simultaneous events.** A violation together with frame completion on the same cycle counts as a violation.
- **Reset** (asynchronous, also mid-frame):
  - State goes to SEARCH and all counters clear.
  - Every output reads 0.
  - The previous-value edge registers reset to 1, the sync idle level.

## Timing
- An input sample at edge n reaches S1 at n+1. Outputs are registered from S1-derived values and are valid at n+2, a fixed 2-cycle latency for colour, coordinates, `PIX_VALID` and `FRAME_START`.
- `LOCKED` rises in the same output cycle as the `FRAME_START` of the first frame after lock. That first locked frame's pixels are all valid.
- `LOCKED` falls 2 cycles after the sample that causes the violation. `PIX_VALID` falls in that same cycle.
- An `hs_edge` with hcnt already at saturation is treated as a timeout: one violation is counted, not two.

## Test plan
- **Nominal 640x480 stream from the generator.**
  - After reset, `LOCKED`=0.
  - `LOCKED` rises at the `FRAME_START` of the 3rd frame following the first VSYNC.
  - Then exactly 307200 `PIX_VALID` cycles per frame.
  - The first valid pixel has X=0, Y=0; the last has X=639, Y=479.
  - Colour equals the input delayed by exactly 2 clocks.
- **Short line.** While locked, inject one line of 799 clocks:
  - `LOCKED` and `PIX_VALID` go to 0 at the next `hs_edge` + 2 cycles.
  - `ERR_COUNT`=1.
  - Relock takes 2 good frames after the next VSYNC.
- **Missing HSYNC.** Hold HSYNC high for 1700 clocks:
  - Timeout at hcnt=1600 drops lock.
  - `ERR_COUNT` increments by exactly 1.
- **Frame of 524 lines.** Drops lock at the VSYNC restart; `ERR_COUNT`+1.
- **Async reset mid-active-line** (assert `RESET_N` between clock edges):
  - All outputs are 0 immediately.
  - After release, the block follows the SEARCH → CHECK → LOCKED sequence as in the nominal test.
- **300 injected violations.** `ERR_COUNT` saturates at 255 and does not wrap.
